// File: rtl/sine_taylor_pkg.sv
// Package: sine_taylor_pkg
// Shared Taylor coefficients (Q0.16) and FSM states for the sine summation stage.
package sine_taylor_pkg;

  localparam int K_FRAC = 16;
  localparam int CW     = 16;

  // 1/6, 1/120 and 1/5040 scaled by 2^K_FRAC
  localparam logic [CW-1:0] C3 = 16'd10923;
  localparam logic [CW-1:0] C5 = 16'd546;
  localparam logic [CW-1:0] C7 = 16'd13;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T3   = 3'd1,
    T5   = 3'd2,
    T7   = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/sine_taylor_mac.sv
// Module: sine_taylor_mac
// Registered signed accumulator: load operand<<K_FRAC, or add/subtract operand*coef.
module sine_taylor_mac
  import sine_taylor_pkg::*;
#(
  parameter int W     = 16,
  parameter int ACC_W = W + K_FRAC + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic                    en_i,
  input  logic                    sub_i,
  input  logic [W-1:0]            operand_i,
  input  logic [CW-1:0]           coef_i,
  output logic signed [ACC_W-1:0] acc_d_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic [W+CW-1:0]         prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] load_val;

  assign prod     = {{CW{1'b0}}, operand_i} * {{W{1'b0}}, coef_i};
  assign prod_ext = signed'(ACC_W'(prod));
  assign load_val = signed'(ACC_W'({operand_i, {K_FRAC{1'b0}}}));

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = load_val;
    end else if (en_i) begin
      acc_d = sub_i ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // The top saturates the value being written so the result lands on the same edge
  assign acc_d_o = acc_d;

endmodule

// File: rtl/sine_taylor_sum.sv
// Module: sine_taylor_sum
// Sums x - x^3/6 + x^5/120 - x^7/5040 with one shared MAC. Optional macro SINE_TAYLOR_ROUND_EN.
module sine_taylor_sum
  import sine_taylor_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 14,
  parameter int NUM  = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] x,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] x5,
  input  logic [W-1:0] x7,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] sin
);

  localparam int ACC_W = W + K_FRAC + 2;
  localparam logic signed [ACC_W-1:0] SIN_MAX = signed'(ACC_W'({W{1'b1}}));

  if (NUM != 3 && NUM != 5 && NUM != 7) begin : g_bad_num
    $error("sine_taylor_sum: NUM must be 3, 5 or 7");
  end
  if (FRAC >= W) begin : g_bad_frac
    $error("sine_taylor_sum: FRAC must be smaller than W");
  end

  state_e                  state_q, state_d;
  logic [W-1:0]            x3_q, x5_q, x7_q;
  logic [W-1:0]            sin_q;
  logic                    out_vld_q;
  logic                    mac_load, mac_en, mac_sub;
  logic [W-1:0]            mac_operand;
  logic [CW-1:0]           mac_coef;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_rnd;
  logic signed [ACC_W-1:0] acc_shift;
  logic [W-1:0]            sat_val;
  logic                    finish;

  // Sequencing: one product per term state, sign alternating with the series
  always_comb begin
    state_d     = state_q;
    mac_load    = 1'b0;
    mac_en      = 1'b0;
    mac_sub     = 1'b0;
    mac_operand = x;
    mac_coef    = '0;
    case (state_q)
      IDLE: begin
        if (in_vld) begin
          state_d  = T3;
          mac_load = 1'b1;
        end
      end
      T3: begin
        mac_en      = 1'b1;
        mac_sub     = 1'b1;
        mac_operand = x3_q;
        mac_coef    = C3;
        state_d     = (NUM >= 5) ? T5 : DONE;
      end
      T5: begin
        mac_en      = 1'b1;
        mac_operand = x5_q;
        mac_coef    = C5;
        state_d     = (NUM == 7) ? T7 : DONE;
      end
      T7: begin
        mac_en      = 1'b1;
        mac_sub     = 1'b1;
        mac_operand = x7_q;
        mac_coef    = C7;
        state_d     = DONE;
      end
      DONE: begin
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x3_q <= '0;
      x5_q <= '0;
      x7_q <= '0;
    end else if (state_q == IDLE && in_vld) begin
      x3_q <= x3;
      x5_q <= x5;
      x7_q <= x7;
    end
  end

  sine_taylor_mac #(.W(W), .ACC_W(ACC_W)) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (mac_load),
    .en_i      (mac_en),
    .sub_i     (mac_sub),
    .operand_i (mac_operand),
    .coef_i    (mac_coef),
    .acc_d_o   (acc_d)
  );

`ifdef SINE_TAYLOR_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_HALF = signed'(ACC_W'(1)) <<< (K_FRAC - 1);
  assign acc_rnd = acc_d + RND_HALF;
`else
  assign acc_rnd = acc_d;
`endif

  assign acc_shift = acc_rnd >>> K_FRAC;

  always_comb begin
    if (acc_shift[ACC_W-1]) begin
      sat_val = '0;
    end else if (acc_shift > SIN_MAX) begin
      sat_val = '1;
    end else begin
      sat_val = acc_shift[W-1:0];
    end
  end

  assign finish = (state_q == T3 || state_q == T5 || state_q == T7) && (state_d == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (finish) begin
      sin_q     <= sat_val;
      out_vld_q <= 1'b1;
    end else if (state_q == DONE && out_rdy) begin
      out_vld_q <= 1'b0;
    end
  end

  assign in_rdy  = (state_q == IDLE);
  assign out_vld = out_vld_q;
  assign sin     = sin_q;

endmodule

// File: tb/tb_sine_taylor_sum.sv
// Testbench: tb_sine_taylor_sum
// Randomized scoreboard bench for sine_taylor_sum (NUM=7), honours SINE_TAYLOR_ROUND_EN.
module tb_sine_taylor_sum;

  localparam int W   = 16;
  localparam int NUM = 7;
  localparam int LAT = (NUM - 1) / 2;
`ifdef SINE_TAYLOR_ROUND_EN
  localparam int EXP_HALF = 7855;
`else
  localparam int EXP_HALF = 7854;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [W-1:0] x = '0;
  logic [W-1:0] x3 = '0;
  logic [W-1:0] x5 = '0;
  logic [W-1:0] x7 = '0;
  logic         out_vld;
  logic         out_rdy = 1'b0;
  logic [W-1:0] sin;

  int   expQ[$];
  int   accQ[$];
  int   cycle = 0;
  int   checkCount = 0;
  int   passCount = 0;
  logic forceStall = 1'b0;
  logic prevVld = 1'b0;
  logic rdyDue = 1'b0;
  logic [W-1:0] prevSin = '0;

  sine_taylor_sum #(.W(W), .FRAC(14), .NUM(NUM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .x       (x),
    .x3      (x3),
    .x5      (x5),
    .x7      (x7),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .sin     (sin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Downstream readiness: random unless a stall is being forced
  always @(posedge clk) begin
    #2;
    out_rdy = forceStall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference: the truncated series evaluated directly in integer arithmetic
  function automatic int refSin(input int xv, input int x3v, input int x5v, input int x7v);
    longint acc;
    longint q;
    acc = longint'(xv) * 65536 - longint'(x3v) * 10923;
    if (NUM >= 5) acc += longint'(x5v) * 546;
    if (NUM == 7) acc -= longint'(x7v) * 13;
`ifdef SINE_TAYLOR_ROUND_EN
    acc += 32768;
`endif
    q = acc >>> 16;
    if (q < 0) return 0;
    if (q > 65535) return 65535;
    return int'(q);
  endfunction

  function automatic void powers(input int xv, output int p3, output int p5, output int p7);
    longint x2, a3, a5, a7;
    x2 = (longint'(xv) * xv) >>> 14;
    a3 = (x2 * xv) >>> 14;
    a5 = (a3 * x2) >>> 14;
    a7 = (a5 * x2) >>> 14;
    p3 = int'(a3 & 64'hFFFF);
    p5 = int'(a5 & 64'hFFFF);
    p7 = int'(a7 & 64'hFFFF);
  endfunction

  // Called just after a rising edge; returns just after the accepting edge
  task automatic applyStimulus(input int xv, input int x3v, input int x5v, input int x7v,
                               input int expv);
    int n = 0;
    in_vld = 1'b1;
    x  = 16'(xv);
    x3 = 16'(x3v);
    x5 = 16'(x5v);
    x7 = 16'(x7v);
    while (!in_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_rdy) begin
      checkOutput("in_rdy wait timeout", int'(in_rdy), 1);
      in_vld = 1'b0;
      return;
    end
    expQ.push_back(expv);
    @(posedge clk); #1;
    accQ.push_back(cycle);
    in_vld = 1'b0;
    x  = 16'($urandom);
    x3 = 16'($urandom);
    x5 = 16'($urandom);
    x7 = 16'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() > 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("scoreboard drain", expQ.size(), 0);
  endtask

  // Monitor: latency, result value, stall stability and in_rdy recovery
  always @(negedge clk) begin
    if (!rst_n) begin
      prevVld = 1'b0;
      rdyDue  = 1'b0;
    end else begin
      if (rdyDue) checkOutput("in_rdy after output handshake", int'(in_rdy), 1);
      rdyDue = 1'b0;
      if (out_vld) begin
        checkOutput("in_rdy low while result pending", int'(in_rdy), 0);
        if (!prevVld) begin
          if (accQ.size() == 0) checkOutput("spurious out_vld", int'(out_vld), 0);
          else checkOutput("out_vld latency", cycle - accQ.pop_front(), LAT);
        end else begin
          checkOutput("sin stable under backpressure", int'(sin), int'(prevSin));
        end
        if (out_rdy) begin
          if (expQ.size() == 0) checkOutput("unexpected result", int'(out_vld), 0);
          else checkOutput("sin value", int'(sin), expQ.pop_front());
          rdyDue = 1'b1;
        end
      end
      prevVld = out_vld && !out_rdy;
      prevSin = sin;
    end
  end

  initial begin
    int p3, p5, p7, junk, n;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_vld", int'(out_vld), 0);
    checkOutput("reset sin", int'(sin), 0);
    checkOutput("reset in_rdy", int'(in_rdy), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(8192, 2048, 512, 128, EXP_HALF);
    applyStimulus(0, 65535, 0, 0, 0);
    applyStimulus(65535, 0, 65535, 0, 65535);
    powers(25736, p3, p5, p7);
    applyStimulus(25736, p3, p5, p7, refSin(25736, p3, p5, p7));

    for (int i = 0; i < 40; i++) begin
      int xv;
      xv = int'($urandom_range(0, 25736));
      if (i % 2 == 0) begin
        powers(xv, p3, p5, p7);
      end else begin
        p3 = int'($urandom_range(0, 65535));
        p5 = int'($urandom_range(0, 65535));
        p7 = int'($urandom_range(0, 65535));
      end
      applyStimulus(xv, p3, p5, p7, refSin(xv, p3, p5, p7));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    waitDrain();

    // Long stall with junk input traffic that must not be accepted
    forceStall = 1'b1;
    applyStimulus(8192, 2048, 512, 128, EXP_HALF);
    n = 0;
    while (!out_vld && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("out_vld before stall", int'(out_vld), 1);
    repeat (10) begin
      @(posedge clk); #1;
      in_vld = 1'b1;
      x  = 16'($urandom);
      x3 = 16'($urandom);
      x5 = 16'($urandom);
      x7 = 16'($urandom);
    end
    in_vld = 1'b0;
    forceStall = 1'b0;
    waitDrain();

    // Abort in T5: the in-flight result must vanish
    applyStimulus(12000, 3000, 700, 150, refSin(12000, 3000, 700, 150));
    @(posedge clk); #1;
    rst_n = 1'b0;
    junk = expQ.pop_back();
    junk = accQ.pop_back();
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("mid-op reset out_vld", int'(out_vld), 0);
    checkOutput("mid-op reset sin", int'(sin), 0);
    checkOutput("mid-op reset in_rdy", int'(in_rdy), 1);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    checkOutput("no result after abort", int'(out_vld), 0);
    powers(20000, p3, p5, p7);
    applyStimulus(20000, p3, p5, p7, refSin(20000, p3, p5, p7));
    applyStimulus(8192, 2048, 512, 128, EXP_HALF);
    waitDrain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
